tfe_pool_out: RTL and testbench
===============================

# tfe_pool_out

Downstream post-processing stage for the TensorFlowE MAC core. It consumes the core's 8-bit result stream (`Datos_out` qualified by `Ena_out`) and optionally applies ReLU. It then max-pools over a programmable window of 1–8 results and buffers the pooled values in a small show-ahead FIFO. The chip-level wrapper reads that FIFO with a one-cycle read strobe.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `DATA_W`, 8: sample width; signed two's complement.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `Datos_in`  in  DATA_W  result byte from core `Datos_out`.
- `Ena_in`  in  1  sample valid; driven by core `Ena_out`; one sample per high cycle.
- `relu_en`  in  1  1 = negative samples replaced by 0 before pooling.
- `pool_len`  in  3  window length minus one (0 → 1 sample, 7 → 8 samples).
- `flush`  in  1  drop partial window, empty FIFO, clear `overflow`.
- `rd_en`  in  1  pop head entry; ignored when empty.
- `Datos_out`  out  DATA_W  FIFO head (show-ahead); 0 when empty.
- `Ena_out`  out  1  FIFO non-empty.
- `full`  out  1  FIFO holds DEPTH entries.
- `overflow`  out  1  sticky; a pooled result was dropped.

## Operation
- Per accepted sample, `v = (relu_en && Datos_in[DATA_W-1]) ? 0 : Datos_in`.
- Window state:
  - `win_max` (DATA_W signed).
  - `win_cnt` (3 bits).
  - `win_len` (3 bits, latched).
  - `in_win` flag.
- First sample of a window (`in_win`=0):
  - `win_max <= v`, `win_len <= pool_len`, `win_cnt <= 0`, `in_win <= 1`.
  - If `pool_len`==0, the window completes immediately.
- Later samples: `win_max <= max_signed(win_max, v)`, `win_cnt <= win_cnt+1`.
- Window completes on the sample where `win_cnt == win_len` (counted including the first sample):
  - The max of all window samples (including the current one) is pushed to the FIFO.
  - `in_win <= 0`.
- `pool_len` changes mid-window have no effect until the next window starts.
- Signed comparison throughout: 8'h80 (−128) < 8'h00 < 8'h7F.
- FIFO:
  - Push on window completion; pop on `rd_en` && `Ena_out`.
  - Push while full and no pop in the same cycle: the value is dropped and `overflow <= 1`.
  - Push while full with a pop in the same cycle: both happen, occupancy unchanged, no overflow.
  - Push and pop while non-full: both happen.
- `flush` takes priority over `Ena_in` and `rd_en` in the same cycle: the sample is discarded and no pop occurs. It clears `in_win`, `win_cnt`, FIFO pointers/count and `overflow`.
- `rst` has the same effect as `flush`, plus `win_max <= 0` and `win_len <= 0`.

## Timing
- All outputs registered or decoded from registered state; no combinational input→output path.
- Reset values: `Datos_out`=0, `Ena_out`=0, `full`=0, `overflow`=0.
- Latency:
  - Completing sample at edge t lands in the FIFO at t.
  - If the FIFO was empty, `Ena_out`=1 and `Datos_out`=value during cycle t+1.
- Pop: `rd_en` sampled at edge t; the next entry (or 0 / `Ena_out`=0) is visible in cycle t+1.
- Throughput: one sample per cycle sustained; back-to-back `Ena_in` allowed.
- `overflow` rises in the cycle after the dropped push and holds until `flush`/`rst`.
- `rst` or `flush` mid-window: the partial window is lost. The first `Ena_in` after release starts a new window.

## Structure
- Package `tfe_pkg`:
  - `DATA_W` default.
  - `pool_len_t` (3-bit typedef).
  - `function relu8` and `function smax8`, shared with future activation stages.
- Sub-module `tfe_fifo` (parameters DEPTH, DATA_W):
  - Ports: `push`, `pop`, `clr`, `din`, `dout`, `empty`, `full`.
  - Pointer/count with `$clog2(DEPTH)+1`-bit count.
  - `dout`=0 when empty.
- Top level holds the ReLU/pool datapath, window counter and the `overflow` flag.

## Test plan
- **Reset:** assert `rst` 2 cycles mid-stream → all outputs 0; the next 2-sample window with `pool_len`=1 and inputs 3, 9 yields 9.
- **Pass-through:** `pool_len`=0, `relu_en`=0, inputs 8'hF0, 8'h05 → FIFO holds F0 then 05; `Ena_out` rises the cycle after the first `Ena_in`.
- **ReLU + pool:** `relu_en`=1, `pool_len`=3, inputs 8'h80, 8'hFF, 8'h02, 8'h01 → single push of 02; with `relu_en`=0, inputs 80, FF, FE, 81 → FF.
- **Full/overflow:** DEPTH=4, `pool_len`=0, 5 samples with no reads → `full`=1 after the 4th and `overflow`=1 after the 5th. Reading 4 times returns samples 1–4 in order.
- **Simultaneous push/pop at full:** full FIFO, `Ena_in` and `rd_en` in the same cycle → no overflow, `full` stays 1, head advances.
- **Flush mid-window:** `pool_len`=3, 2 samples, then `flush` asserted together with `Ena_in` → FIFO empty and no push. The next 4 samples 1, 2, 3, 4 push 4.

Source files
------------

// File: rtl/tfe_pkg.sv
// Shared types and helpers for the TensorFlowE post-processing stages.
package tfe_pkg;

  localparam int DATA_W_DEFAULT = 8;

  typedef logic [2:0] pool_len_t;

  function automatic logic [DATA_W_DEFAULT-1:0] relu8(
    input logic [DATA_W_DEFAULT-1:0] x,
    input logic                      en
  );
    return (en && x[DATA_W_DEFAULT-1]) ? '0 : x;
  endfunction

  function automatic logic [DATA_W_DEFAULT-1:0] smax8(
    input logic [DATA_W_DEFAULT-1:0] a,
    input logic [DATA_W_DEFAULT-1:0] b
  );
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

endpackage

// File: rtl/tfe_pool_out_if.sv
// Sample stream in, pooled FIFO read side out; master = core/wrapper, slave = pool stage.
interface tfe_pool_out_if
  import tfe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
);
  logic [DATA_W-1:0] Datos_in;
  logic              Ena_in;
  logic              relu_en;
  pool_len_t         pool_len;
  logic              flush;
  logic              rd_en;
  logic [DATA_W-1:0] Datos_out;
  logic              Ena_out;
  logic              full;
  logic              overflow;

  modport master (
    output Datos_in, Ena_in, relu_en, pool_len, flush, rd_en,
    input  Datos_out, Ena_out, full, overflow
  );

  modport slave (
    input  Datos_in, Ena_in, relu_en, pool_len, flush, rd_en,
    output Datos_out, Ena_out, full, overflow
  );
endinterface

// File: rtl/tfe_fifo.sv
// Show-ahead FIFO; a push into a full FIFO is accepted only alongside a pop.
module tfe_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              push,
  input  logic              pop,
  input  logic              clr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign dout      = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/tfe_pool_out.sv
// ReLU + signed max-pool over 1..8 samples of the MAC result stream, buffered in a FIFO.
module tfe_pool_out
  import tfe_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  tfe_pool_out_if.slave bus
);
  logic [DATA_W-1:0] r_win_max;
  pool_len_t         r_win_cnt;
  pool_len_t         r_win_len;
  logic              r_in_win;
  logic              r_overflow;

  logic [DATA_W-1:0] w_v;
  logic [DATA_W-1:0] w_max_new;
  pool_len_t         w_cnt_inc;
  logic              w_done;
  logic              w_push;
  logic              w_pop;
  logic              w_clr;
  logic              w_empty;
  logic              w_full;

  // Package helpers are 8-bit; other widths fall back to the equivalent inline logic.
  if (DATA_W == DATA_W_DEFAULT) begin : g_pkg_fn
    assign w_v       = relu8(bus.Datos_in, bus.relu_en);
    assign w_max_new = r_in_win ? smax8(r_win_max, w_v) : w_v;
  end else begin : g_generic
    assign w_v       = (bus.relu_en && bus.Datos_in[DATA_W-1]) ? '0 : bus.Datos_in;
    assign w_max_new = (r_in_win && ($signed(r_win_max) > $signed(w_v))) ? r_win_max : w_v;
  end

  assign w_cnt_inc = r_win_cnt + 3'd1;
  assign w_done    = bus.Ena_in && (r_in_win ? (w_cnt_inc == r_win_len)
                                             : (bus.pool_len == 3'd0));
  assign w_push    = w_done && !bus.flush;
  assign w_pop     = bus.rd_en && !bus.flush;
  assign w_clr     = rst || bus.flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_win_max  <= '0;
      r_win_cnt  <= '0;
      r_win_len  <= '0;
      r_in_win   <= 1'b0;
      r_overflow <= 1'b0;
    end else if (bus.flush) begin
      r_win_cnt  <= '0;
      r_in_win   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push && w_full && !(w_pop && !w_empty)) begin
        r_overflow <= 1'b1;
      end
      if (bus.Ena_in) begin
        r_win_max <= w_max_new;
        if (!r_in_win) begin
          r_win_len <= bus.pool_len;
          r_win_cnt <= '0;
        end else begin
          r_win_cnt <= w_cnt_inc;
        end
        r_in_win <= !w_done;
      end
    end
  end

  tfe_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .push  (w_push),
    .pop   (w_pop),
    .clr   (w_clr),
    .din   (w_max_new),
    .dout  (bus.Datos_out),
    .empty (w_empty),
    .full  (w_full)
  );

  assign bus.Ena_out  = !w_empty;
  assign bus.full     = w_full;
  assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_tfe_pool_out.sv
// Directed vector table for tfe_pool_out plus hand-written fill/drain and empty-read sequences.
module tb_tfe_pool_out;
  logic clk;
  logic rst;

  tfe_pool_out_if #(.DATA_W(8)) bus ();

  tfe_pool_out #(.DEPTH(4), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       flush;
    logic       ena;
    logic [7:0] din;
    logic       relu;
    logic [2:0] plen;
    logic       rd;
    logic [7:0] e_dout;
    logic       e_ena;
    logic       e_full;
    logic       e_ovf;
  } vec_t;

  vec_t vecs [80];
  int   n_vec;
  int   n_cmp;
  int   n_bad;

  task automatic add(input logic r, input logic f, input logic e, input logic [7:0] d,
                     input logic rl, input logic [2:0] pl, input logic rd,
                     input logic [7:0] xd, input logic xe, input logic xf, input logic xo);
    vecs[n_vec].rst    = r;
    vecs[n_vec].flush  = f;
    vecs[n_vec].ena    = e;
    vecs[n_vec].din    = d;
    vecs[n_vec].relu   = rl;
    vecs[n_vec].plen   = pl;
    vecs[n_vec].rd     = rd;
    vecs[n_vec].e_dout = xd;
    vecs[n_vec].e_ena  = xe;
    vecs[n_vec].e_full = xf;
    vecs[n_vec].e_ovf  = xo;
    n_vec++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rst          = 1'b0;
    bus.flush    = 1'b0;
    bus.Ena_in   = 1'b0;
    bus.Datos_in = 8'h00;
    bus.rd_en    = 1'b0;
  endtask

  initial begin
    int n;
    n_vec = 0;
    n_cmp = 0;
    n_bad = 0;
    rst          = 1'b1;
    bus.flush    = 1'b0;
    bus.Ena_in   = 1'b0;
    bus.Datos_in = 8'h00;
    bus.relu_en  = 1'b0;
    bus.pool_len = 3'd0;
    bus.rd_en    = 1'b0;

    // rst flush ena din relu plen rd | dout ena full ovf
    add(1,0,0,8'h00,0,3'd0,0, 8'h00,0,0,0);
    add(1,0,0,8'h00,0,3'd0,0, 8'h00,0,0,0);
    // pass-through
    add(0,0,1,8'hF0,0,3'd0,0, 8'hF0,1,0,0);
    add(0,0,1,8'h05,0,3'd0,0, 8'hF0,1,0,0);
    add(0,0,0,8'h00,0,3'd0,1, 8'h05,1,0,0);
    add(0,0,0,8'h00,0,3'd0,1, 8'h00,0,0,0);
    // ReLU + pool of 4
    add(0,0,1,8'h80,1,3'd3,0, 8'h00,0,0,0);
    add(0,0,1,8'hFF,1,3'd3,0, 8'h00,0,0,0);
    add(0,0,1,8'h02,1,3'd3,0, 8'h00,0,0,0);
    add(0,0,1,8'h01,1,3'd3,0, 8'h02,1,0,0);
    add(0,0,0,8'h00,1,3'd3,1, 8'h00,0,0,0);
    // signed pool of negatives
    add(0,0,1,8'h80,0,3'd3,0, 8'h00,0,0,0);
    add(0,0,1,8'hFF,0,3'd3,0, 8'h00,0,0,0);
    add(0,0,1,8'hFE,0,3'd3,0, 8'h00,0,0,0);
    add(0,0,1,8'h81,0,3'd3,0, 8'hFF,1,0,0);
    add(0,0,0,8'h00,0,3'd3,1, 8'h00,0,0,0);
    // reset mid-stream loses FIFO contents and the partial window
    add(0,0,1,8'h11,0,3'd0,0, 8'h11,1,0,0);
    add(0,0,1,8'h50,0,3'd1,0, 8'h11,1,0,0);
    add(1,0,0,8'h00,0,3'd1,0, 8'h00,0,0,0);
    add(1,0,0,8'h00,0,3'd1,0, 8'h00,0,0,0);
    add(0,0,1,8'h03,0,3'd1,0, 8'h00,0,0,0);
    add(0,0,1,8'h09,0,3'd1,0, 8'h09,1,0,0);
    add(0,0,0,8'h00,0,3'd1,1, 8'h00,0,0,0);
    // fill, overflow, drain
    add(0,0,1,8'h01,0,3'd0,0, 8'h01,1,0,0);
    add(0,0,1,8'h02,0,3'd0,0, 8'h01,1,0,0);
    add(0,0,1,8'h03,0,3'd0,0, 8'h01,1,0,0);
    add(0,0,1,8'h04,0,3'd0,0, 8'h01,1,1,0);
    add(0,0,1,8'h05,0,3'd0,0, 8'h01,1,1,1);
    add(0,0,0,8'h00,0,3'd0,1, 8'h02,1,0,1);
    add(0,0,0,8'h00,0,3'd0,1, 8'h03,1,0,1);
    add(0,0,0,8'h00,0,3'd0,1, 8'h04,1,0,1);
    add(0,0,0,8'h00,0,3'd0,1, 8'h00,0,0,1);
    add(0,1,0,8'h00,0,3'd0,0, 8'h00,0,0,0);
    // push + pop while full
    add(0,0,1,8'h0A,0,3'd0,0, 8'h0A,1,0,0);
    add(0,0,1,8'h0B,0,3'd0,0, 8'h0A,1,0,0);
    add(0,0,1,8'h0C,0,3'd0,0, 8'h0A,1,0,0);
    add(0,0,1,8'h0D,0,3'd0,0, 8'h0A,1,1,0);
    add(0,0,1,8'h0E,0,3'd0,1, 8'h0B,1,1,0);
    add(0,0,0,8'h00,0,3'd0,1, 8'h0C,1,0,0);
    add(0,0,0,8'h00,0,3'd0,1, 8'h0D,1,0,0);
    add(0,0,0,8'h00,0,3'd0,1, 8'h0E,1,0,0);
    add(0,0,0,8'h00,0,3'd0,1, 8'h00,0,0,0);
    // flush mid-window together with a sample
    add(0,0,1,8'h07,0,3'd3,0, 8'h00,0,0,0);
    add(0,0,1,8'h08,0,3'd3,0, 8'h00,0,0,0);
    add(0,1,1,8'h7F,0,3'd3,0, 8'h00,0,0,0);
    add(0,0,1,8'h01,0,3'd3,0, 8'h00,0,0,0);
    add(0,0,1,8'h02,0,3'd3,0, 8'h00,0,0,0);
    add(0,0,1,8'h03,0,3'd3,0, 8'h00,0,0,0);
    add(0,0,1,8'h04,0,3'd3,0, 8'h04,1,0,0);
    add(0,1,0,8'h00,0,3'd3,1, 8'h00,0,0,0);
    // pool_len change mid-window is ignored
    add(0,0,1,8'h05,0,3'd2,0, 8'h00,0,0,0);
    add(0,0,1,8'h06,0,3'd0,0, 8'h00,0,0,0);
    add(0,0,1,8'h04,0,3'd0,0, 8'h06,1,0,0);
    add(0,0,0,8'h00,0,3'd0,1, 8'h00,0,0,0);
    // longest window, 8 samples
    add(0,0,1,8'h10,0,3'd7,0, 8'h00,0,0,0);
    add(0,0,1,8'hF0,0,3'd7,0, 8'h00,0,0,0);
    add(0,0,1,8'h20,0,3'd7,0, 8'h00,0,0,0);
    add(0,0,1,8'h7F,0,3'd7,0, 8'h00,0,0,0);
    add(0,0,1,8'h80,0,3'd7,0, 8'h00,0,0,0);
    add(0,0,1,8'h00,0,3'd7,0, 8'h00,0,0,0);
    add(0,0,1,8'h01,0,3'd7,0, 8'h00,0,0,0);
    add(0,0,1,8'h02,0,3'd7,0, 8'h7F,1,0,0);
    add(0,0,0,8'h00,0,3'd7,1, 8'h00,0,0,0);

    for (int i = 0; i < n_vec; i++) begin
      rst          = vecs[i].rst;
      bus.flush    = vecs[i].flush;
      bus.Ena_in   = vecs[i].ena;
      bus.Datos_in = vecs[i].din;
      bus.relu_en  = vecs[i].relu;
      bus.pool_len = vecs[i].plen;
      bus.rd_en    = vecs[i].rd;
      @(posedge clk);
      #1;
      $display("vec %0d: rst=%0b fl=%0b ena=%0b din=%02h rd=%0b -> dout=%02h ena_out=%0b full=%0b ovf=%0b",
               i, vecs[i].rst, vecs[i].flush, vecs[i].ena, vecs[i].din, vecs[i].rd,
               bus.Datos_out, bus.Ena_out, bus.full, bus.overflow);
      check($sformatf("v%0d Datos_out", i), 32'(bus.Datos_out), 32'(vecs[i].e_dout));
      check($sformatf("v%0d Ena_out", i),   32'(bus.Ena_out),   32'(vecs[i].e_ena));
      check($sformatf("v%0d full", i),      32'(bus.full),      32'(vecs[i].e_full));
      check($sformatf("v%0d overflow", i),  32'(bus.overflow),  32'(vecs[i].e_ovf));
    end

    // Fill until full with a bounded cycle budget, then drain in order.
    idle_inputs();
    bus.relu_en  = 1'b0;
    bus.pool_len = 3'd0;
    n = 0;
    while (!bus.full && n < 10) begin
      bus.Ena_in   = 1'b1;
      bus.Datos_in = 8'h20 + 8'(n);
      @(posedge clk);
      #1;
      $display("fill %0d: din=%02h -> full=%0b", n, bus.Datos_in, bus.full);
      n++;
    end
    idle_inputs();
    check("fill pushes to full", 32'(n), 32'd4);
    check("fill overflow", 32'(bus.overflow), 32'd0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain head %0d", k), 32'(bus.Datos_out), 32'h20 + 32'(k));
      bus.rd_en = 1'b1;
      @(posedge clk);
      #1;
      $display("drain %0d: -> dout=%02h ena_out=%0b", k, bus.Datos_out, bus.Ena_out);
    end
    bus.rd_en = 1'b0;
    check("drain empty", 32'(bus.Ena_out), 32'd0);

    // Read strobe on an empty FIFO coinciding with a push must not pop the new entry.
    bus.rd_en    = 1'b1;
    bus.Ena_in   = 1'b1;
    bus.Datos_in = 8'h55;
    @(posedge clk);
    #1;
    idle_inputs();
    $display("empty rd + push: -> dout=%02h ena_out=%0b", bus.Datos_out, bus.Ena_out);
    check("empty rd Ena_out", 32'(bus.Ena_out), 32'd1);
    check("empty rd Datos_out", 32'(bus.Datos_out), 32'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
